// File: rtl/demux_buffered.sv
// 1-to-2 buffered demultiplexer: each accepted word is queued in the FIFO of the lane
// named by selector; the two lanes drain independently through their own handshakes.
module demux_buffered #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic             selector,
   input  logic [WIDTH-1:0] data_in,
   output logic             ready_in,
   output logic [WIDTH-1:0] data_out0,
   output logic             valid_out0,
   input  logic             ready_out0,
   output logic [WIDTH-1:0] data_out1,
   output logic             valid_out1,
   input  logic             ready_out1
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [2][DEPTH];
   logic [PW-1:0]    wr_ptr [2];
   logic [PW-1:0]    rd_ptr [2];
   logic [CW-1:0]    count  [2];

   logic [1:0] full;
   logic [1:0] empty;
   logic [1:0] push;
   logic [1:0] pop;
   logic [1:0] ready_out;

   assign ready_out = {ready_out1, ready_out0};

   for (genvar l = 0; l < 2; l++) begin : g_lane
      assign full[l]  = (count[l] == CW'(DEPTH));
      assign empty[l] = (count[l] == '0);
      assign pop[l]   = !empty[l] && ready_out[l];
   end

   // A full lane refuses pushes even while it is popping: no pass-through path.
   assign ready_in = selector ? !full[1] : !full[0];
   assign push[0]  = valid_in && ready_in && !selector;
   assign push[1]  = valid_in && ready_in && selector;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int l = 0; l < 2; l++) begin
            wr_ptr[l] <= '0;
            rd_ptr[l] <= '0;
            count[l]  <= '0;
         end
      end else begin
         for (int l = 0; l < 2; l++) begin
            if (push[l]) wr_ptr[l] <= wr_ptr[l] + PW'(1);
            if (pop[l])  rd_ptr[l] <= rd_ptr[l] + PW'(1);
            count[l] <= count[l] + CW'(push[l]) - CW'(pop[l]);
         end
      end
   end

   // Storage needs no reset; emptiness masks stale contents on the outputs.
   always_ff @(posedge clk) begin
      for (int l = 0; l < 2; l++) begin
         if (push[l]) mem[l][wr_ptr[l]] <= data_in;
      end
   end

   assign valid_out0 = !empty[0];
   assign valid_out1 = !empty[1];
   assign data_out0  = empty[0] ? '0 : mem[0][rd_ptr[0]];
   assign data_out1  = empty[1] ? '0 : mem[1][rd_ptr[1]];

endmodule
